serial_port_uart: RTL and testbench

- Peripheral on the far side of the processor's byte-wide serial port. It accepts bytes the processor writes, queues them, and serialises them onto a UART TX line.
- It also deserialises a UART RX line into a one-byte holding register that the processor reads with a valid/rden handshake.
- It drives the processor's serial_ready_in / serial_valid_in / serial_in and consumes its serial_out / serial_wren_out / serial_rden_out. Frame format is 8N1, LSB first.

---
 rtl/serial_port_pkg.sv | 19 +
 rtl/serial_tx_fifo.sv | 42 ++++
 rtl/serial_port_uart.sv | 232 +++++++++++++++++++++++
 tb/tb_serial_port_uart.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_port_pkg.sv
// Shared UART definitions for the serial port peripheral: frame geometry and FSM state encodings.
package serial_port_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = UART_IDLE,
    StStart = UART_START,
    StData  = UART_DATA,
    StStop  = UART_STOP
  } uart_state_e;

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous TX byte queue; pointers carry an extra wrap bit to tell full from empty.
module serial_tx_fifo import serial_port_pkg::*; #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = DATA_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_port_uart.sv
// Processor-side serial port peripheral: queued 8N1 UART transmitter and a single-byte
// receive holding register with valid/rden handshake.
module serial_port_uart import serial_port_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_wdata,
  input  logic       proc_wren,
  output logic       proc_ready,
  output logic [7:0] proc_rdata,
  output logic       proc_valid,
  input  logic       proc_rden,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_overflow,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LastBit = 3'(DATA_BITS - 1);

  // ---------------- TX path ----------------
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  uart_state_e          tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 tx_overflow_q;

  // Ready reflects pre-edge state, so a write while full is dropped even if a pop frees a slot.
  assign proc_ready  = !fifo_full;
  assign fifo_push   = proc_wren && !fifo_full;
  assign tx_overflow = tx_overflow_q;

  serial_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (proc_wdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    uart_tx    = IDLE_LEVEL;
    unique case (tx_state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = '0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        uart_tx = 1'b0;
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StData: begin
        uart_tx = tx_shift_q[0];
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LastBit) tx_state_d = StStop;
          else                     tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StStop: begin
        uart_tx = IDLE_LEVEL;
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued frames run back-to-back.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_dout;
            tx_state_d = StStart;
          end else begin
            tx_state_d = StIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q    <= StIdle;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_overflow_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      if (proc_wren && fifo_full) tx_overflow_q <= 1'b1;
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]      rx_sync_q;
  logic            rx_s;
  uart_state_e     rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_done, frame_err_d, frame_err_q;
  logic [7:0]      rdata_q, rdata_d;
  logic            valid_q, valid_d, overrun_q, overrun_d;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == HalfEnd) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (rx_cnt_q == BitEnd) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == LastBit) rx_state_d = StStop;
          else                     rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (rx_cnt_q == BitEnd) begin
          rx_cnt_d    = '0;
          rx_state_d  = StIdle;
          byte_done   = rx_s;
          frame_err_d = !rx_s;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // A completing byte wins over a same-cycle read; it only counts as overrun if nobody read.
  always_comb begin
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (byte_done) begin
      rdata_d = rx_shift_q;
      valid_d = 1'b1;
      if (valid_q && !proc_rden) overrun_d = 1'b1;
    end else if (proc_rden) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync_q   <= {2{IDLE_LEVEL}};
      rx_state_q  <= StIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_sync_q   <= {rx_sync_q[0], uart_rx};
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign proc_rdata   = rdata_q;
  assign proc_valid   = valid_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_port_uart.sv
// Directed bench for serial_port_uart at CLKS_PER_BIT=16, TX_FIFO_DEPTH=8.
module tb_serial_port_uart;

  logic       clock;
  logic       reset;
  logic [7:0] proc_wdata;
  logic       proc_wren;
  logic       proc_ready;
  logic [7:0] proc_rdata;
  logic       proc_valid;
  logic       proc_rden;
  logic       uart_tx;
  logic       uart_rx;
  logic       tx_overflow;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cycles = 0;
  logic       mid_valid;
  logic [7:0] mid_rdata;

  serial_port_uart dut (
    .clock        (clock),
    .reset        (reset),
    .proc_wdata   (proc_wdata),
    .proc_wren    (proc_wren),
    .proc_ready   (proc_ready),
    .proc_rdata   (proc_rdata),
    .proc_valid   (proc_valid),
    .proc_rden    (proc_rden),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .tx_overflow  (tx_overflow),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (rx_frame_err === 1'b1) ferr_cycles++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(posedge clock); #1;
    proc_wdata = b;
    proc_wren  = 1'b1;
    @(posedge clock); #1;
    proc_wren  = 1'b0;
  endtask

  // Samples one full frame starting at the next falling clock edge.
  task automatic tx_expect_frame(input logic [7:0] b);
    logic [9:0] fr;
    int bad;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        @(negedge clock);
        if (uart_tx !== fr[i]) bad++;
      end
      check_eq($sformatf("tx_%02h_bit%0d_bad_cycles", b, i), bad, 0);
    end
  endtask

  task automatic watch_tx_idle(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  // Drives one 8N1 frame; captures the holding register 3 cycles after the stop-bit midpoint.
  task automatic rx_frame(input logic [7:0] b, input logic stop_lvl, input bit rd_on_load);
    @(posedge clock); #1;
    uart_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clock);
      #1 uart_rx = b[i];
    end
    repeat (16) @(posedge clock);
    #1 uart_rx = stop_lvl;
    for (int j = 0; j < 16; j++) begin
      @(posedge clock); #1;
      if (rd_on_load && j == 9) proc_rden = 1'b1;
      if (j == 10) begin
        proc_rden = 1'b0;
        mid_valid = proc_valid;
        mid_rdata = proc_rdata;
      end
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int vbad;
    reset      = 1'b0;
    uart_rx    = 1'b1;
    proc_wren  = 1'b0;
    proc_rden  = 1'b0;
    proc_wdata = 8'h00;

    // Reset values and a quiet line.
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_eq("rst_uart_tx", uart_tx, 1);
    check_eq("rst_proc_ready", proc_ready, 1);
    check_eq("rst_proc_valid", proc_valid, 0);
    check_eq("rst_proc_rdata", proc_rdata, 0);
    check_eq("rst_tx_overflow", tx_overflow, 0);
    check_eq("rst_rx_overrun", rx_overrun, 0);
    check_eq("rst_rx_frame_err", rx_frame_err, 0);
    vbad = 0;
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) lows++;
      if (proc_valid !== 1'b0) vbad++;
    end
    check_eq("idle_tx_low_cycles", lows, 0);
    check_eq("idle_valid_cycles", vbad, 0);
    check_eq("idle_frame_err_cycles", ferr_cycles, 0);

    // Single byte: line still high between write edge and pop edge, then the 160-cycle frame.
    write_byte(8'hA5);
    @(negedge clock);
    check_eq("tx_still_idle_after_write", uart_tx, 1);
    tx_expect_frame(8'hA5);
    @(negedge clock);
    check_eq("tx_idle_after_a5", uart_tx, 1);

    // Burst of ten writes on consecutive cycles; the tenth hits a full queue.
    fork
      begin
        for (int k = 1; k <= 10; k++) begin
          @(posedge clock); #1;
          if (k == 9) begin
            check_eq("burst_ready_before_w9", proc_ready, 1);
            check_eq("burst_no_overflow_yet", tx_overflow, 0);
          end
          if (k == 10) check_eq("burst_ready_after_w9", proc_ready, 0);
          proc_wdata = 8'(k);
          proc_wren  = 1'b1;
        end
        @(posedge clock); #1;
        proc_wren = 1'b0;
        check_eq("burst_tx_overflow", tx_overflow, 1);
      end
      begin
        repeat (3) @(posedge clock);
        for (int k = 1; k <= 9; k++) tx_expect_frame(8'(k));
      end
    join
    watch_tx_idle(40, lows);
    check_eq("burst_no_tenth_frame", lows, 0);
    check_eq("overflow_sticky", tx_overflow, 1);

    // Receive 0x3C, then read it out.
    rx_frame(8'h3C, 1'b1, 1'b0);
    check_eq("rx3c_valid_by_mid_plus3", mid_valid, 1);
    check_eq("rx3c_rdata_by_mid_plus3", mid_rdata, 8'h3C);
    @(posedge clock); #1 proc_rden = 1'b1;
    @(posedge clock); #1 proc_rden = 1'b0;
    check_eq("rden_clears_valid", proc_valid, 0);
    check_eq("rden_keeps_rdata", proc_rdata, 8'h3C);
    @(posedge clock); #1 proc_rden = 1'b1;
    @(posedge clock); #1 proc_rden = 1'b0;
    check_eq("rden_idle_valid", proc_valid, 0);
    check_eq("rden_idle_rdata", proc_rdata, 8'h3C);

    // Unread byte, then a byte landing on the same cycle as a read: no overrun.
    rx_frame(8'h11, 1'b1, 1'b0);
    check_eq("rx11_valid", proc_valid, 1);
    check_eq("rx11_rdata", proc_rdata, 8'h11);
    rx_frame(8'h44, 1'b1, 1'b1);
    check_eq("rx44_load_with_rden_valid", mid_valid, 1);
    check_eq("rx44_load_with_rden_rdata", mid_rdata, 8'h44);
    check_eq("rx44_no_overrun", rx_overrun, 0);
    check_eq("rx44_valid_after", proc_valid, 1);

    // Unread byte overwritten: overrun.
    rx_frame(8'h22, 1'b1, 1'b0);
    check_eq("rx22_rdata", proc_rdata, 8'h22);
    check_eq("rx22_valid", proc_valid, 1);
    check_eq("rx22_overrun", rx_overrun, 1);

    // Short low glitch is a false start.
    @(posedge clock); #1 uart_rx = 1'b0;
    repeat (4) @(posedge clock);
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check_eq("glitch_no_frame_err", ferr_cycles, 0);
    check_eq("glitch_valid", proc_valid, 1);
    check_eq("glitch_rdata", proc_rdata, 8'h22);

    // Bad stop bit: one-cycle error pulse, holding register untouched.
    rx_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(posedge clock);
    #1;
    check_eq("ferr_pulse_cycles", ferr_cycles, 1);
    check_eq("ferr_valid_unchanged", proc_valid, 1);
    check_eq("ferr_rdata_unchanged", proc_rdata, 8'h22);

    // Reset in the middle of a transmit frame with another byte queued.
    write_byte(8'h5A);
    write_byte(8'h5B);
    repeat (50) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check_eq("midtx_rst_uart_tx", uart_tx, 1);
    check_eq("midtx_rst_ready", proc_ready, 1);
    check_eq("midtx_rst_valid", proc_valid, 0);
    check_eq("midtx_rst_rdata", proc_rdata, 0);
    check_eq("midtx_rst_overflow", tx_overflow, 0);
    check_eq("midtx_rst_overrun", rx_overrun, 0);
    @(posedge clock); #1 reset = 1'b1;
    watch_tx_idle(200, lows);
    check_eq("midtx_rst_fifo_flushed", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
